// File: rtl/pwm_demod_pkg.sv
// pwm_demod_pkg
//   Shared types and constants for the PWM demodulator.
//   - state_e   : framing state machine encoding (HUNT / ALIGN / LOCKED)
//   - window_of : PWM period in clocks for a given level resolution
package pwm_demod_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,  // waiting for any rising edge
    ALIGN  = 2'd1,  // one rise seen, waiting for a confirming rise one window later
    LOCKED = 2'd2   // framing confirmed, one level per window
  } state_e;

  localparam int DEFAULT_BITS = 6;

  // PWM period is 2^bits clocks.
  function automatic int window_of(input int bits);
    return 1 << bits;
  endfunction

endpackage

// File: rtl/pwm_edge_sync.sv
// pwm_edge_sync
//   Brings the asynchronous PWM line into the clock domain and derives the
//   edge information the framing logic needs.
//   Ports:
//     clock  - system clock
//     reset  - synchronous, active-high; clears all flops
//     pwm    - raw PWM line (asynchronous)
//     s      - synchronized line (2-flop synchronizer output)
//     s_d    - s delayed by one clock
//     rise   - s & ~s_d, one-cycle rising-edge indication
module pwm_edge_sync (
  input  logic clock,
  input  logic reset,
  input  logic pwm,
  output logic s,
  output logic s_d,
  output logic rise
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic dly_q,  dly_d;

  always_comb begin
    meta_d = pwm;
    sync_d = meta_q;
    dly_d  = sync_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      dly_q  <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  assign s    = sync_q;
  assign s_d  = dly_q;
  assign rise = sync_q & ~dly_q;

endmodule

// File: rtl/pwm_demod.sv
// pwm_demod
//   Recovers the BITS-bit level from a fixed-period PWM stream
//   (period 2^BITS clocks, high time = level clocks, rising edge at period
//   start). Locks to the period framing, emits one level per period and
//   strobes err on framing violations.
//   Ports:
//     clock       - system clock (only clock)
//     reset       - synchronous, active-high
//     pwm         - PWM input line (asynchronous)
//     level       - last recovered level, held between strobes
//     level_valid - one-cycle strobe when level is updated
//     locked      - high while the framing state machine is LOCKED
//     err         - one-cycle framing-error strobe (never with level_valid)
module pwm_demod
  import pwm_demod_pkg::*;
#(
  parameter int BITS = DEFAULT_BITS
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            pwm,
  output logic [BITS-1:0] level,
  output logic            level_valid,
  output logic            locked,
  output logic            err
);

  localparam int WINDOW = window_of(BITS);
  localparam int HC_W   = BITS + 1;
  localparam logic [BITS-1:0] PH_ONE  = {{(BITS-1){1'b0}}, 1'b1};
  localparam logic [HC_W-1:0] HC_FULL = HC_W'(WINDOW);

  // ---------------------------------------------------------------------------
  // Input synchronizer and edge detect
  // ---------------------------------------------------------------------------
  logic s, s_dly, rise;

  pwm_edge_sync u_sync (
    .clock (clock),
    .reset (reset),
    .pwm   (pwm),
    .s     (s),
    .s_d   (s_dly),
    .rise  (rise)
  );

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [BITS-1:0] phase_q, phase_d;
  logic [HC_W-1:0] hc_q,    hc_d;
  logic [BITS-1:0] level_q, level_d;
  logic            level_valid_q, level_valid_d;
  logic            err_q,   err_d;

  logic            phase0;    // registered phase is 0 (window boundary)
  logic            overflow;  // line was high for a whole window
  logic [HC_W-1:0] s_ext;
  logic [HC_W-1:0] hc_acc;    // next high count if the window continues/restarts
  logic            emit;
  logic            fault;

  always_comb begin
    phase0   = (phase_q == '0);
    overflow = (hc_q == HC_FULL);
    s_ext    = {{BITS{1'b0}}, s};
    // A rise is always treated as phase 0 of a new window, so the count
    // reloads from s on either a registered phase 0 or a rise.
    hc_acc   = (phase0 || rise) ? s_ext : (hc_q + s_ext);

    state_d  = state_q;
    phase_d  = rise ? PH_ONE : (phase_q + PH_ONE);
    hc_d     = hc_acc;
    emit     = 1'b0;
    fault    = 1'b0;

    unique case (state_q)
      HUNT: begin
        phase_d = '0;
        hc_d    = s_ext;
        if (rise) begin
          state_d = ALIGN;
          phase_d = PH_ONE;
        end
      end

      ALIGN: begin
        if (overflow) begin
          fault   = 1'b1;
          state_d = HUNT;
        end else if (phase0) begin
          if (rise) begin
            state_d = LOCKED;
            emit    = 1'b1;
          end else begin
            // Confirming edge missing: quietly start over.
            state_d = HUNT;
          end
        end
        // Rise at phase != 0 simply restarts the window (phase_d/hc_d above).
      end

      LOCKED: begin
        if (overflow || (phase0 && s_dly)) begin
          // Line high across the boundary: framing is gone.
          fault   = 1'b1;
          state_d = HUNT;
        end else if (phase0) begin
          // s_dly is 0 here, so this is either a rise or a level-0 window.
          emit = 1'b1;
        end else if (rise) begin
          // Early edge: drop the broken window, treat this rise as a new start.
          fault   = 1'b1;
          state_d = ALIGN;
        end
      end

      default: begin
        state_d = HUNT;
      end
    endcase

    if (state_d == HUNT) begin
      phase_d = '0;
      hc_d    = '0;
    end

    // err has priority; emit and fault are mutually exclusive by construction.
    level_valid_d = emit & ~fault;
    err_d         = fault;
    level_d       = level_valid_d ? hc_q[BITS-1:0] : level_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= HUNT;
      phase_q       <= '0;
      hc_q          <= '0;
      level_q       <= '0;
      level_valid_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      hc_q          <= hc_d;
      level_q       <= level_d;
      level_valid_q <= level_valid_d;
      err_q         <= err_d;
    end
  end

  assign level       = level_q;
  assign level_valid = level_valid_q;
  assign locked      = (state_q == LOCKED);
  assign err         = err_q;

endmodule
